mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the core's single shared memory port. It sits between the instruction-fetch stage and the load/store unit of `multiple_instructions` and the unified program/data memory. Only one transaction is outstanding at a time. Simultaneous requests are granted round-robin, and a watchdog terminates any access the memory does not acknowledge in time.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width of all ports.
- `DATA_WIDTH`, default 32: data width of all ports. Must be a multiple of 8.
- `TIMEOUT`, default 15: maximum number of cycles spent waiting for `mem_ack`. Must be ≥1.

Ports:
- `clk`  in  1  — the block's only clock.
- `reset`  in  1  — synchronous, active-low reset.
- `if_req`  in  1  — fetch request. Held high until `if_ack`.
- `if_addr`  in  ADDR_WIDTH  — fetch address. Stable while `if_req` is high.
- `if_ack`  out  1  — one-cycle completion pulse for fetch.
- `if_rdata`  out  DATA_WIDTH  — fetched word. Valid while `if_ack` is high.
- `if_err`  out  1  — fetch timed out. Valid while `if_ack` is high.
- `ls_req`  in  1  — load/store request. Held high until `ls_ack`.
- `ls_we`  in  1  — 1 = store, 0 = load.
- `ls_addr`  in  ADDR_WIDTH  — load/store address.
- `ls_wdata`  in  DATA_WIDTH  — store data.
- `ls_wstrb`  in  DATA_WIDTH/8  — store byte enables.
- `ls_ack`, `ls_rdata`, `ls_err`  out  1 / DATA_WIDTH / 1  — same meaning as the fetch equivalents.
- `mem_req`  out  1  — memory access active.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  — registered command to memory.
- `mem_ack`  in  1  — memory completion. May arrive in the same cycle `mem_req` first rises.
- `mem_rdata`  in  DATA_WIDTH  — read data. Valid while `mem_ack` is high.
- `busy`  out  1  — high whenever the block is not in IDLE.

## Operation
FSM states: IDLE, WAIT, RESP.

**IDLE**
- With no request pending, remain in IDLE.
- If only one of `if_req`/`ls_req` is high, grant that requester.
- If both are high, grant the requester that was not granted last.
  - The `last` register resets to "ls", so fetch wins the first tie after reset.
- On a grant:
  - latch the granted requester's address, we, wdata and wstrb into the `mem_*` registers;
  - fetch latches `mem_we=0` and `mem_wstrb=0`; a load latches `mem_wstrb=0`, regardless of `ls_wstrb`;
  - update `last`, clear the timeout counter, and go to WAIT.

**WAIT**
- `mem_req=1`.
- If `mem_ack=1`: register `mem_rdata` (store: register 0 instead), clear `err`, and go to RESP.
- Otherwise increment the counter.
  - The counter is `$clog2(TIMEOUT+1)` bits wide and saturates.
- If the counter reaches TIMEOUT with no ack: set rdata=0 and `err=1`, then go to RESP.

**RESP**
- Assert the granted requester's `*_ack` for exactly one cycle, with registered rdata/err.
- Go to IDLE.

**General rules**
- The non-granted `*_ack` is 0, and its rdata/err outputs are 0.
- `mem_ack` outside WAIT is ignored. It does not change state.
- `mem_*` command outputs hold their last value outside WAIT. Only `mem_req` qualifies them.
- A requester must deassert `req` in the cycle after its ack. The block does not re-check `req` in WAIT/RESP; dropping `req` early does not abort the access.

**Reset (`reset=0` at a rising edge)**
- State=IDLE, `last`=ls, counter=0.
- All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, both acks, rdata, err, `busy`.
- Reset mid-transaction abandons it. No ack is issued, and `mem_req` is low from the next cycle.

## Timing
- Cycle 0: IDLE samples the request.
- Cycle 1: `mem_req`=1. With a zero-wait memory, `mem_ack` can arrive here.
- Cycle 2: `*_ack`=1.
- Minimum latency is 2 cycles, request to ack. The minimum issue interval is 3 cycles.
  - A request still high in cycle 3 after its ack is treated as a new request. This is the requester's error.
- Each memory wait cycle adds one cycle.
- Timeout case:
  - `mem_req` is high for TIMEOUT+1 cycles;
  - ack arrives TIMEOUT+2 cycles after the grant, with err=1.
- An ack arriving in the same cycle the counter reaches TIMEOUT wins: data is returned with err=0.
- With both requesters continuously pending, grants alternate strictly. Neither requester waits more than one transaction.

## Test plan
- **Single fetch, zero-wait memory.**
  - Stimulus: `if_addr=0x10`; memory returns 0x00C50593 in cycle 1.
  - Required: `mem_req` high for cycle 1 only; `if_ack`=1 in cycle 2 with `if_rdata=0x00C50593`, `if_err=0`; `ls_ack` stays 0.
- **Byte store with 3 memory wait cycles.**
  - Stimulus: `ls_we=1`, `ls_addr=0x104`, `ls_wdata=0xAB`, `ls_wstrb=4'b0001`.
  - Required: `mem_we=1`, `mem_wstrb=0001`; `mem_req` high 4 cycles; `ls_ack` 5 cycles after the request with `ls_rdata=0`.
- **Load with strobes presented.**
  - Stimulus: `ls_we=0`, `ls_wstrb=4'b1111`.
  - Required: `mem_wstrb=0000`, `mem_we=0`.
- **Contention.**
  - Stimulus: both requests held from cycle 0 after reset, each re-raised immediately.
  - Required: grant order fetch, ls, fetch, ls; acks in cycles 2, 5, 8, 11.
- **Timeout.**
  - Stimulus: `mem_ack` never asserted, TIMEOUT=15.
  - Required: `mem_req` high 16 cycles; `if_ack`=1 with `if_err=1`, `if_rdata=0` in cycle 17; back to IDLE, `busy=0`.
- **Reset in WAIT.**
  - Stimulus: `reset=0` at cycle 2 of a stalled load.
  - Required: from the next cycle `mem_req=0`, `busy=0`, no `ls_ack`; a fresh fetch after release of reset wins a tie.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and single-outstanding sequencer for the shared memory port,
// with a watchdog that terminates accesses the memory never acknowledges.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    output logic                    o_if_ack,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    output logic                    o_if_err,
    input  logic                    i_ls_req,
    input  logic                    i_ls_we,
    input  logic [ADDR_WIDTH-1:0]   i_ls_addr,
    input  logic [DATA_WIDTH-1:0]   i_ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_ls_wstrb,
    output logic                    o_ls_ack,
    output logic [DATA_WIDTH-1:0]   o_ls_rdata,
    output logic                    o_ls_err,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic                    i_mem_ack,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                  r_state;
    logic                    r_last;
    logic                    r_sel;
    logic [CW-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [DATA_WIDTH/8-1:0] r_mem_wstrb;
    logic                    w_pick_ls;
    logic                    w_if_ack;
    logic                    w_ls_ack;
    // r_last=1 means ls was granted last, so fetch wins the next tie
    assign w_pick_ls = i_ls_req & (~i_if_req | ~r_last);
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_sel       <= 1'b0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_if_req | i_ls_req) begin
                    r_sel       <= w_pick_ls;
                    r_last      <= w_pick_ls;
                    r_cnt       <= '0;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= w_pick_ls & i_ls_we;
                    r_mem_addr  <= w_pick_ls ? i_ls_addr : i_if_addr;
                    r_mem_wdata <= w_pick_ls ? i_ls_wdata : '0;
                    r_mem_wstrb <= (w_pick_ls & i_ls_we) ? i_ls_wstrb : '0;
                    r_state     <= WAIT;
                end
                WAIT: if (i_mem_ack) begin
                    r_rdata   <= r_mem_we ? '0 : i_mem_rdata;
                    r_err     <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_state   <= RESP;
                end else if (r_cnt == CW'(TIMEOUT)) begin
                    r_rdata   <= '0;
                    r_err     <= 1'b1;
                    r_mem_req <= 1'b0;
                    r_state   <= RESP;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign w_if_ack    = (r_state == RESP) & ~r_sel;
    assign w_ls_ack    = (r_state == RESP) & r_sel;
    assign o_if_ack    = w_if_ack;
    assign o_if_rdata  = w_if_ack ? r_rdata : '0;
    assign o_if_err    = w_if_ack & r_err;
    assign o_ls_ack    = w_ls_ack;
    assign o_ls_rdata  = w_ls_ack ? r_rdata : '0;
    assign o_ls_err    = w_ls_ack & r_err;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wstrb = r_mem_wstrb;
    assign o_busy      = r_state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a scoreboard queue; a monitor pops and checks each ack.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic        o_if_ack;
    logic [31:0] o_if_rdata;
    logic        o_if_err;
    logic        i_ls_req = 1'b0;
    logic        i_ls_we = 1'b0;
    logic [31:0] i_ls_addr = '0;
    logic [31:0] i_ls_wdata = '0;
    logic [3:0]  i_ls_wstrb = '0;
    logic        o_ls_ack;
    logic [31:0] o_ls_rdata;
    logic        o_ls_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_busy;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata), .o_if_err(o_if_err),
        .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_wstrb(i_ls_wstrb),
        .o_ls_ack(o_ls_ack), .o_ls_rdata(o_ls_rdata), .o_ls_err(o_ls_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ls;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
        int          reqc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          mem_wait = 0;
    bit          ovr = 1'b0;
    logic [31:0] ovr_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // memory model: acks after mem_wait stall cycles; mem_wait >= 16 never acks
    int wcnt = 0;
    always @(negedge clk) begin
        if (o_mem_req) begin
            i_mem_ack = (wcnt == mem_wait);
            i_mem_rdata = i_mem_ack ? (ovr ? ovr_data : {16'hCAFE, o_mem_addr[15:0]}) : 32'h0;
            wcnt++;
        end else begin
            i_mem_ack = 1'b0;
            i_mem_rdata = '0;
            wcnt = 0;
        end
    end

    int          reqc = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    logic [3:0]  cap_wstrb;
    always @(negedge clk) begin
        if (!reset) begin
            reqc = 0;
        end else begin
            if (o_mem_req) begin
                if (reqc == 0) begin
                    cap_addr = o_mem_addr;
                    cap_we = o_mem_we;
                    cap_wdata = o_mem_wdata;
                    cap_wstrb = o_mem_wstrb;
                end
                reqc++;
            end
            if (o_if_ack || o_ls_ack) begin
                chk("ack_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_who", {31'd0, o_ls_ack}, {31'd0, e.ls});
                    chk("other_ack", {31'd0, e.ls ? o_if_ack : o_ls_ack}, 32'd0);
                    chk("other_rdata", e.ls ? o_if_rdata : o_ls_rdata, 32'd0);
                    chk("rdata", e.ls ? o_ls_rdata : o_if_rdata, e.rdata);
                    chk("err", {31'd0, e.ls ? o_ls_err : o_if_err}, {31'd0, e.err});
                    chk("ack_cycle", cyc, e.cyc);
                    chk("mem_req_cycles", reqc, e.reqc);
                    chk("mem_addr", cap_addr, e.addr);
                    chk("mem_we", {31'd0, cap_we}, {31'd0, e.we});
                    chk("mem_wstrb", {28'd0, cap_wstrb}, {28'd0, e.wstrb});
                    if (e.we) chk("mem_wdata", cap_wdata, e.wdata);
                end
                reqc = 0;
            end
        end
    end

    task automatic push(input bit ls, input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] rdata, input bit err,
                        input int c, input int rc);
        exp_t e;
        e.ls = ls; e.addr = addr; e.we = we; e.wdata = wdata; e.wstrb = wstrb;
        e.rdata = rdata; e.err = err; e.cyc = c; e.reqc = rc;
        sb.push_back(e);
    endtask

    // single transaction: drive at a negedge (cycle 0), hold until ack, then drop
    task automatic run1(input bit ls, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int wt, input logic [31:0] rdata, input bit err,
                        input int lat, input int rc);
        bit got = 1'b0;
        mem_wait = wt;
        push(ls, addr, we, wdata, ls ? (we ? wstrb : 4'h0) : 4'h0, rdata, err, cyc + lat, rc);
        if (ls) begin
            i_ls_req = 1'b1; i_ls_we = we; i_ls_addr = addr; i_ls_wdata = wdata; i_ls_wstrb = wstrb;
        end else begin
            i_if_req = 1'b1; i_if_addr = addr;
        end
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = ls ? o_ls_ack : o_if_ack;
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        i_if_req = 1'b0;
        i_ls_req = 1'b0;
    endtask

    // both requesters held until each has n acks
    task automatic contend(input int n);
        int nif = 0;
        int nls = 0;
        i_if_req = 1'b1;
        i_ls_req = 1'b1;
        for (int k = 0; k < 60 && (nif < n || nls < n); k++) begin
            @(negedge clk);
            if (o_if_ack) nif++;
            if (o_ls_ack) nls++;
            if (nif >= n) i_if_req = 1'b0;
            if (nls >= n) i_ls_req = 1'b0;
        end
        chk("contend_if_acks", nif, n);
        chk("contend_ls_acks", nls, n);
        i_if_req = 1'b0;
        i_ls_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_if_ack", {31'd0, o_if_ack}, 32'd0);
        chk("rst_ls_ack", {31'd0, o_ls_ack}, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_wstrb", {28'd0, o_mem_wstrb}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        // fetch, zero-wait memory
        ovr = 1'b1; ovr_data = 32'h00C50593;
        run1(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'h00C50593, 1'b0, 2, 1);
        ovr = 1'b0;
        repeat (2) @(negedge clk);
        // byte store, 3 wait cycles
        run1(1'b1, 1'b1, 32'h104, 32'hAB, 4'b0001, 3, 32'h0, 1'b0, 5, 4);
        repeat (2) @(negedge clk);
        // load presenting strobes
        run1(1'b1, 1'b0, 32'h108, 32'h55, 4'b1111, 1, 32'hCAFE0108, 1'b0, 3, 2);
        repeat (2) @(negedge clk);
        // timeout
        run1(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 99, 32'h0, 1'b1, 17, 16);
        @(negedge clk);
        chk("timeout_idle_busy", {31'd0, o_busy}, 32'd0);
        // contention right after reset
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mem_wait = 0;
        i_if_addr = 32'h20;
        i_ls_addr = 32'h200; i_ls_we = 1'b0; i_ls_wstrb = 4'h0;
        push(1'b0, 32'h20, 1'b0, 32'h0, 4'h0, 32'hCAFE0020, 1'b0, cyc + 2, 1);
        push(1'b1, 32'h200, 1'b0, 32'h0, 4'h0, 32'hCAFE0200, 1'b0, cyc + 5, 1);
        push(1'b0, 32'h20, 1'b0, 32'h0, 4'h0, 32'hCAFE0020, 1'b0, cyc + 8, 1);
        push(1'b1, 32'h200, 1'b0, 32'h0, 4'h0, 32'hCAFE0200, 1'b0, cyc + 11, 1);
        contend(2);
        repeat (2) @(negedge clk);
        // reset during a stalled load
        mem_wait = 99;
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h300; i_ls_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        chk("stall_mem_req", {31'd0, o_mem_req}, 32'd1);
        reset = 1'b0;
        i_ls_req = 1'b0;
        @(negedge clk);
        chk("rst_wait_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_wait_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_wait_ls_ack", {31'd0, o_ls_ack}, 32'd0);
        reset = 1'b1;
        mem_wait = 0;
        i_if_addr = 32'h44;
        push(1'b0, 32'h44, 1'b0, 32'h0, 4'h0, 32'hCAFE0044, 1'b0, cyc + 2, 1);
        push(1'b1, 32'h300, 1'b0, 32'h0, 4'h0, 32'hCAFE0300, 1'b0, cyc + 5, 1);
        contend(1);
        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
